pad_output_ctrl: RTL and testbench

Output-direction counterpart of the ASIC input pad cell. Registers the value, output-enable and attributes that drive a bidirectional pad, and sequences output-enable transitions so the pad never drives during a bus turnaround. It sits between the pad-control/pad-ring logic and the pad standard cell's data-in/OE pins. A small FSM inserts a programmable setup window before driving and a dead window after releasing.

---
 rtl/pad_ctrl_pkg.sv | 26 ++
 rtl/pad_ctrl_cnt.sv | 40 ++++
 rtl/pad_output_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pad_output_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pad_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pad_ctrl_pkg
// Shared definitions for the pad output controller:
//   - pad_drv_state_e : output-enable sequencing states
//   - PAD_ATTR_RST_BIT: bit value that the applied pad attributes reset to
//   - cnt_width()     : width of a down-counter that must hold max(a,b), >= 1 bit
// -----------------------------------------------------------------------------
package pad_ctrl_pkg;

  typedef enum logic [1:0] {
    HIZ     = 2'd0,
    PRESET  = 2'd1,
    DRIVE   = 2'd2,
    RELEASE = 2'd3
  } pad_drv_state_e;

  // Applied attributes come out of reset as all-zero.
  localparam logic PAD_ATTR_RST_BIT = 1'b0;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pad_ctrl_cnt.sv
// -----------------------------------------------------------------------------
// pad_ctrl_cnt
// Loadable down-counter with a zero flag. Load has priority over decrement;
// decrementing saturates at zero.
// Ports:
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset (count -> 0)
//   load_i     : load load_val_i on the next edge
//   load_val_i : value to load
//   dec_i      : decrement on the next edge (ignored when already zero)
//   zero_o     : count is zero
// -----------------------------------------------------------------------------
module pad_ctrl_cnt
  import pad_ctrl_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pad_output_ctrl.sv
// -----------------------------------------------------------------------------
// pad_output_ctrl
// Registers value, output-enable and attributes for a bidirectional pad cell and
// sequences OE so the pad never drives during a bus turnaround: a setup window
// (data presented, OE low) before driving and a dead window after releasing.
// Optional feature macro: PAD_OUTPUT_CTRL_SLEW_LIMIT_EN -- while driving,
// pad_in_o changes at most once per MIN_PULSE cycles.
// Ports:
//   clk_i                : clock
//   rst_i                : asynchronous active-high reset
//   pad_out_req_i        : value to drive on the pad
//   pad_oe_req_i         : request to drive the pad
//   pad_attributes_req_i : requested pad attributes
//   pad_in_o             : value to pad cell data input
//   pad_oe_o             : pad cell output enable
//   pad_attributes_o     : applied attributes (frozen outside HIZ)
//   busy_o               : high in PRESET or RELEASE
// -----------------------------------------------------------------------------
module pad_output_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int PADATTR      = 16,
  parameter int SETUP_CYCLES = 1,
  parameter int DEAD_CYCLES  = 2,
  parameter int MIN_PULSE    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pad_out_req_i,
  input  logic               pad_oe_req_i,
  input  logic [PADATTR-1:0] pad_attributes_req_i,
  output logic               pad_in_o,
  output logic               pad_oe_o,
  output logic [PADATTR-1:0] pad_attributes_o,
  output logic               busy_o
);

  localparam int CNT_W = cnt_width(SETUP_CYCLES, DEAD_CYCLES);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DEAD_LD  = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  // Empty marker scope appears in the hierarchy if MIN_PULSE is out of range.
  if (MIN_PULSE < 1) begin : g_min_pulse_out_of_range
  end

  pad_drv_state_e     state_q, state_d;
  logic               oe_req_q;
  logic               pad_in_q, pad_in_d;
  logic               pad_oe_q, pad_oe_d;
  logic               busy_q, busy_d;
  logic [PADATTR-1:0] attr_q, attr_d;

  logic               cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]   cnt_val;

  // The OE request is registered before the FSM acts on it, so a request
  // captured at edge N moves the FSM at edge N+1. This also means a request
  // changing on a counter-expiry edge is only seen on the following edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= HIZ;
      oe_req_q <= 1'b0;
      pad_in_q <= 1'b0;
      pad_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      attr_q   <= {PADATTR{PAD_ATTR_RST_BIT}};
    end else begin
      state_q  <= state_d;
      oe_req_q <= pad_oe_req_i;
      pad_in_q <= pad_in_d;
      pad_oe_q <= pad_oe_d;
      busy_q   <= busy_d;
      attr_q   <= attr_d;
    end
  end

  // Next state and setup/dead counter control.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = SETUP_LD;
    cnt_dec  = 1'b0;
    unique case (state_q)
      HIZ: begin
        if (oe_req_q) begin
          if (SETUP_CYCLES == 0) begin
            state_d = DRIVE;
          end else begin
            state_d  = PRESET;
            cnt_load = 1'b1;
            cnt_val  = SETUP_LD;
          end
        end
      end
      PRESET: begin
        // Abort before ever driving needs no dead time.
        if (!oe_req_q)     state_d = HIZ;
        else if (cnt_zero) state_d = DRIVE;
        else               cnt_dec = 1'b1;
      end
      DRIVE: begin
        if (!oe_req_q) begin
          if (DEAD_CYCLES == 0) begin
            state_d = HIZ;
          end else begin
            state_d  = RELEASE;
            cnt_load = 1'b1;
            cnt_val  = DEAD_LD;
          end
        end
      end
      RELEASE: begin
        if (cnt_zero) state_d = HIZ;
        else          cnt_dec = 1'b1;
      end
      default: state_d = HIZ;
    endcase
  end

  pad_ctrl_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

`ifdef PAD_OUTPUT_CTRL_SLEW_LIMIT_EN
  localparam int SLEW_W = cnt_width(MIN_PULSE - 1, 0);
  localparam logic [SLEW_W-1:0] SLEW_LD = SLEW_W'(MIN_PULSE - 1);

  logic              slew_load, slew_dec, slew_zero;
  logic [SLEW_W-1:0] slew_val;

  pad_ctrl_cnt #(.W(SLEW_W)) u_slew_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (slew_load),
    .load_val_i (slew_val),
    .dec_i      (slew_dec),
    .zero_o     (slew_zero)
  );
`endif

  // Output next values. OE and busy are decoded from the next state so they
  // line up with the state register.
  always_comb begin
    pad_oe_d = (state_d == DRIVE);
    busy_d   = (state_d == PRESET) || (state_d == RELEASE);
    attr_d   = (state_q == HIZ) ? pad_attributes_req_i : attr_q;
    pad_in_d = pad_out_req_i;
`ifdef PAD_OUTPUT_CTRL_SLEW_LIMIT_EN
    slew_load = 1'b0;
    slew_val  = '0;
    slew_dec  = 1'b0;
    if (state_q != DRIVE) begin
      // Window is held clear outside DRIVE so the first change is immediate.
      slew_load = 1'b1;
    end else if (!slew_zero) begin
      // Inside the window: hold; the latest request is sampled on expiry.
      pad_in_d = pad_in_q;
      slew_dec = 1'b1;
    end else if (pad_out_req_i != pad_in_q) begin
      slew_load = 1'b1;
      slew_val  = SLEW_LD;
    end
`endif
    if (state_q == RELEASE) begin
      pad_in_d = pad_in_q;
    end
  end

  assign pad_in_o         = pad_in_q;
  assign pad_oe_o         = pad_oe_q;
  assign busy_o           = busy_q;
  assign pad_attributes_o = attr_q;

endmodule

// File: tb/tb_pad_output_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pad_output_ctrl
// Directed bench for pad_output_ctrl (SETUP_CYCLES=1, DEAD_CYCLES=2,
// MIN_PULSE=3). Each step drives inputs, pushes the expected post-edge outputs
// to a scoreboard queue, and pops/compares one edge later.
// -----------------------------------------------------------------------------
module tb_pad_output_ctrl;

  logic        clk;
  logic        rst;
  logic        pad_out_req;
  logic        pad_oe_req;
  logic [15:0] attr_req;
  logic        pad_in;
  logic        pad_oe;
  logic [15:0] attr;
  logic        busy;

  typedef struct packed {
    logic        in;
    logic        oe;
    logic        busy;
    logic [15:0] attr;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  pad_output_ctrl #(
    .PADATTR      (16),
    .SETUP_CYCLES (1),
    .DEAD_CYCLES  (2),
    .MIN_PULSE    (3)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .pad_out_req_i        (pad_out_req),
    .pad_oe_req_i         (pad_oe_req),
    .pad_attributes_req_i (attr_req),
    .pad_in_o             (pad_in),
    .pad_oe_o             (pad_oe),
    .pad_attributes_o     (attr),
    .busy_o               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag);
    exp_t e;
    exp_t got;
    e   = sb.pop_front();
    got = '{in: pad_in, oe: pad_oe, busy: busy, attr: attr};
    vectors++;
    $display("%-16s in=%b oe=%b busy=%b attr=%h", tag, pad_in, pad_oe, busy, attr);
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: got in/oe/busy/attr=%b/%b/%b/%h expected %b/%b/%b/%h",
             tag, got.in, got.oe, got.busy, got.attr, e.in, e.oe, e.busy, e.attr);
    end
  endtask

  task automatic step(input logic out, input logic req, input logic [15:0] a,
                      input logic e_in, input logic e_oe, input logic e_busy,
                      input logic [15:0] e_attr, input string tag);
    pad_out_req = out;
    pad_oe_req  = req;
    attr_req    = a;
    sb.push_back('{in: e_in, oe: e_oe, busy: e_busy, attr: e_attr});
    @(posedge clk);
    #1;
    check(tag);
  endtask

  logic tog;
  logic exp_last;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    pad_out_req = 1'b0;
    pad_oe_req  = 1'b0;
    attr_req    = 16'h0003;

    #2;
    sb.push_back('0);
    check("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Enable with one setup cycle: busy for one cycle, data ahead of OE.
    step(1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0, 16'h0003, "hiz_track");
    step(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0003, "req_sampled");
    step(1'b1, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0003, "preset_busy");
    step(1'b0, 1'b1, 16'h00F0, 1'b0, 1'b1, 1'b0, 16'h0003, "drive_on");

    // Data toggles every cycle while driving; attributes stay frozen.
    exp_last = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tog = ~i[0];
`ifdef PAD_OUTPUT_CTRL_SLEW_LIMIT_EN
      if (i % 3 == 0) exp_last = tog;
`else
      exp_last = tog;
`endif
      step(tog, 1'b1, 16'h00F0, exp_last, 1'b1, 1'b0, 16'h0003, "toggle");
    end

    // Release with dead time, re-request one edge after the drop.
    step(1'b1, 1'b0, 16'h00F0, 1'b1, 1'b1, 1'b0, 16'h0003, "drop_sampled");
    step(1'b0, 1'b1, 16'h00F0, 1'b0, 1'b0, 1'b1, 16'h0003, "release");
    step(1'b1, 1'b1, 16'h00F0, 1'b0, 1'b0, 1'b1, 16'h0003, "dead_hold");
    step(1'b1, 1'b1, 16'h00F0, 1'b0, 1'b0, 1'b0, 16'h0003, "dead_to_hiz");
    step(1'b1, 1'b1, 16'h00F0, 1'b1, 1'b0, 1'b1, 16'h00F0, "reenable_preset");
    step(1'b0, 1'b1, 16'h00F0, 1'b0, 1'b1, 1'b0, 16'h00F0, "reenable_drive");

    // Release fully back to HIZ, then load new attributes.
    step(1'b0, 1'b0, 16'h00F0, 1'b0, 1'b1, 1'b0, 16'h00F0, "drop2");
    step(1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b1, 16'h00F0, "release2");
    step(1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b1, 16'h00F0, "dead2");
    step(1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h00F0, "hiz2");
    step(1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0003, "attr_load");

    // One-cycle request pulse: PRESET aborts to HIZ, OE never rises.
    step(1'b1, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 16'h0003, "pulse_hi");
    step(1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0003, "pulse_preset");
    step(1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0003, "abort_hiz");
    step(1'b1, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 16'h0003, "abort_idle");
    step(1'b1, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0003, "no_dead_preset");
    step(1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0003, "no_dead_drive");

    // Asynchronous reset in the middle of DRIVE, away from any edge.
    #2;
    rst = 1'b1;
    #1;
    sb.push_back('0);
    check("async_reset");
    attr_req = 16'h00A5;
    @(posedge clk);
    #1;
    sb.push_back('0);
    check("reset_held");
    rst = 1'b0;
    step(1'b0, 1'b1, 16'h00A5, 1'b0, 1'b0, 1'b0, 16'h00A5, "post_rst_hiz");
    step(1'b1, 1'b1, 16'h00A5, 1'b1, 1'b0, 1'b1, 16'h00A5, "post_rst_preset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
